target_sequencer: RTL and testbench



---
 rtl/target_sequencer_pkg.sv | 36 +++
 rtl/hold_timer.sv | 39 +++
 rtl/target_sequencer.sv | 176 +++++++++++++++++
 tb/tb_target_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/target_sequencer_pkg.sv
// Shared widths, FSM encoding and small helpers for the target sequencer.
package target_sequencer_pkg;

  localparam int TGT_N = 3;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 24;
  localparam int S_W   = 6;
  localparam int TOT_W = 8;
  localparam int RND_W = 5;
  localparam int SEL_W = 2;
  localparam int TMR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_DRAW   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ERASE  = 3'd4,
    ST_GAP    = 3'd5,
    ST_OVER   = 3'd6
  } state_e;

  function automatic logic [TGT_N-1:0] tgt_onehot(input logic [SEL_W-1:0] sel);
    logic [TGT_N-1:0] oh;
    for (int i = 0; i < TGT_N; i++) begin
      oh[i] = (sel == SEL_W'(i));
    end
    return oh;
  endfunction

  function automatic logic [SEL_W-1:0] tgt_next(input logic [SEL_W-1:0] sel);
    return (sel == SEL_W'(TGT_N - 1)) ? '0 : sel + SEL_W'(1);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter with a zero flag; stops at zero. zero_next_o looks one
// cycle ahead so callers can register outputs aligned with the zero cycle.
module hold_timer
  import target_sequencer_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         zero_next_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o      = (count_q == '0);
  assign zero_next_o = (count_d == '0);

endmodule

// File: rtl/target_sequencer.sv
// Game controller: hands the screen to one target at a time, muxes its pixel
// stream onto the VGA port, sums scores and ends the game on score/round limits.
module target_sequencer
  import target_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ROUNDS         = 30,
  parameter int WIN_SCORE      = 20
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   go,
  input  logic [TGT_N-1:0]       done_t,
  input  logic [TGT_N-1:0]       writeEn_t,
  input  logic [TGT_N*X_W-1:0]   x_t,
  input  logic [TGT_N*Y_W-1:0]   y_t,
  input  logic [TGT_N*C_W-1:0]   colour_t,
  input  logic [TGT_N*S_W-1:0]   score_t,
  output logic [TGT_N-1:0]       active,
  output logic [TGT_N-1:0]       start,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_colour,
  output logic                   vga_plot,
  output logic [TOT_W-1:0]       total_score,
  output logic [RND_W-1:0]       round,
  output logic                   game_over
);

  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RND_W:0]   ROUND_LIM = (RND_W+1)'(ROUNDS);
  localparam logic [TOT_W-1:0] WIN_LIM   = TOT_W'(WIN_SCORE);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  nxt_q, nxt_d;
  logic              seen_q, seen_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic [TGT_N-1:0]  active_q, start_q;
  logic              game_over_q;
  logic [X_W-1:0]    vga_x_q;
  logic [Y_W-1:0]    vga_y_q;
  logic [C_W-1:0]    vga_colour_q;
  logic              vga_plot_q;
  logic [TOT_W-1:0]  total_q;

  logic              tmr_load, tmr_dec, tmr_zero, tmr_zero_next;
  logic [TMR_W-1:0]  tmr_val;
  logic [RND_W:0]    round_inc;
  logic              we_sel;
  logic [TOT_W-1:0]  score_sum;

  hold_timer #(.W(TMR_W)) u_timer (
    .clk_i       (CLOCK_50),
    .rst_i       (reset),
    .load_i      (tmr_load),
    .load_val_i  (tmr_val),
    .dec_i       (tmr_dec),
    .zero_o      (tmr_zero),
    .zero_next_o (tmr_zero_next)
  );

  assign round_inc = {1'b0, round_q} + (RND_W+1)'(1);
  assign we_sel    = writeEn_t[sel_q];
  assign score_sum = TOT_W'(score_t[S_W-1:0]) + TOT_W'(score_t[2*S_W-1:S_W])
                   + TOT_W'(score_t[3*S_W-1:2*S_W]);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    nxt_d    = nxt_q;
    seen_d   = seen_q;
    round_d  = round_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_SELECT;
      ST_SELECT: begin
        sel_d    = nxt_q;
        nxt_d    = tgt_next(nxt_q);
        tmr_load = 1'b1;
        tmr_val  = TO_LOAD;
        state_d  = ST_DRAW;
      end
      ST_DRAW: begin
        // done has priority over a timeout landing in the same cycle
        if (done_t[sel_q]) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
          state_d  = ST_HOLD;
        end else if (tmr_zero) begin
          state_d = ST_GAP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TO_LOAD;
          seen_d   = 1'b0;
          state_d  = ST_ERASE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_ERASE: begin
        tmr_dec = 1'b1;
        if (we_sel) seen_d = 1'b1;
        if ((seen_q && !we_sel) || tmr_zero) state_d = ST_GAP;
      end
      ST_GAP: begin
        round_d = (round_q == '1) ? round_q : round_q + RND_W'(1);
        if ((round_inc == ROUND_LIM) || (total_q >= WIN_LIM)) state_d = ST_OVER;
        else                                                    state_d = ST_SELECT;
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      nxt_q        <= '0;
      seen_q       <= 1'b0;
      round_q      <= '0;
      active_q     <= '0;
      start_q      <= '0;
      game_over_q  <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      total_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      nxt_q       <= nxt_d;
      seen_q      <= seen_d;
      round_q     <= round_d;
      active_q    <= (state_d == ST_DRAW || state_d == ST_HOLD) ? tgt_onehot(sel_d) : '0;
      start_q     <= (state_d == ST_HOLD && tmr_zero_next) ? tgt_onehot(sel_d) : '0;
      game_over_q <= (state_d == ST_OVER);
      if (state_d == ST_IDLE) begin
        vga_x_q      <= '0;
        vga_y_q      <= '0;
        vga_colour_q <= '0;
        vga_plot_q   <= 1'b0;
        total_q      <= '0;
      end else begin
        vga_x_q      <= x_t[sel_q*X_W +: X_W];
        vga_y_q      <= y_t[sel_q*Y_W +: Y_W];
        vga_colour_q <= colour_t[sel_q*C_W +: C_W];
        vga_plot_q   <= we_sel;
        total_q      <= score_sum;
      end
    end
  end

  assign active      = active_q;
  assign start       = start_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_colour_q;
  assign vga_plot    = vga_plot_q;
  assign total_score = total_q;
  assign round       = round_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_target_sequencer.sv
// Directed bench for target_sequencer: pixel/score vector table plus
// hand-written sequences for hold timing, round robin, timeout, win and reset.
module tb_target_sequencer;

  localparam int HOLD = 16;
  localparam int TO   = 64;
  localparam int RNDS = 5;
  localparam int WIN  = 20;

  logic        clk;
  logic        reset;
  logic        go;
  logic [2:0]  done_t;
  logic [2:0]  writeEn_t;
  logic [23:0] x_t;
  logic [20:0] y_t;
  logic [71:0] colour_t;
  logic [17:0] score_t;
  logic [2:0]  active;
  logic [2:0]  start;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [23:0] vga_colour;
  logic        vga_plot;
  logic [7:0]  total_score;
  logic [4:0]  round;
  logic        game_over;

  target_sequencer #(
    .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO), .ROUNDS(RNDS), .WIN_SCORE(WIN)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .go(go), .done_t(done_t), .writeEn_t(writeEn_t),
    .x_t(x_t), .y_t(y_t), .colour_t(colour_t), .score_t(score_t),
    .active(active), .start(start), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .total_score(total_score),
    .round(round), .game_over(game_over)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  typedef struct {
    logic [23:0] x;
    logic [20:0] y;
    logic [71:0] c;
    logic [2:0]  we;
    logic [17:0] s;
    logic [7:0]  ex;
    logic [6:0]  ey;
    logic [23:0] ec;
    logic        ep;
    logic [7:0]  et;
  } vec_t;

  vec_t       vecs[5];
  logic [2:0] exp_q[$];
  int         n_checks = 0;
  int         n_err    = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    go = 1'b0; done_t = '0; writeEn_t = '0;
    x_t = '0; y_t = '0; colour_t = '0; score_t = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_go();
    go = 1'b1; tick(); go = 1'b0;
  endtask

  task automatic wait_active(output logic [2:0] a);
    int n;
    n = 0;
    while (active == 3'b000 && n < 2*TO + 16) begin tick(); n++; end
    a = active;
  endtask

  task automatic check_turn();
    logic [2:0] a;
    logic [2:0] e;
    wait_active(a);
    e = exp_q.pop_front();
    check("active_seq", 32'(a), 32'(e));
  endtask

  task automatic finish_turn(input int idx);
    logic [2:0] oh;
    logic [4:0] old;
    int n;
    oh  = 3'(1 << idx);
    old = round;
    done_t = oh; tick(); done_t = '0;
    n = 0;
    while (start == 3'b000 && n < HOLD + 4) begin tick(); n++; end
    check("start_sel", 32'(start), 32'(oh));
    tick();
    check("active_after_start", 32'(active), 32'(0));
    writeEn_t = oh;
    repeat (3) tick();
    writeEn_t = '0;
    n = 0;
    while (round == old && n < TO + 8) begin tick(); n++; end
    check("round_inc", 32'(round), 32'(old) + 32'd1);
  endtask

  task automatic play_round(input int idx);
    check_turn();
    finish_turn(idx);
  endtask

  initial begin
    vecs[0] = '{ {8'h11,8'h2A,8'h33}, {7'h05,7'h4C,7'h12}, {24'hAAAAAA,24'h123456,24'h0F0F0F},
                 3'b010, {6'd8,6'd7,6'd6}, 8'h2A, 7'h4C, 24'h123456, 1'b1, 8'd21 };
    vecs[1] = '{ {8'hFF,8'h00,8'hFF}, {7'h7F,7'h00,7'h7F}, {24'hFFFFFF,24'h000000,24'hFFFFFF},
                 3'b101, {6'd63,6'd0,6'd63}, 8'h00, 7'h00, 24'h000000, 1'b0, 8'd126 };
    vecs[2] = '{ {8'h80,8'hFE,8'h01}, {7'h40,7'h7F,7'h01}, {24'h800000,24'hFFFFFE,24'h000001},
                 3'b111, {6'd63,6'd63,6'd63}, 8'hFE, 7'h7F, 24'hFFFFFE, 1'b1, 8'd189 };
    vecs[3] = '{ {8'h77,8'h5A,8'h66}, {7'h11,7'h22,7'h33}, {24'h010203,24'hABCDEF,24'h445566},
                 3'b000, {6'd0,6'd0,6'd1}, 8'h5A, 7'h22, 24'hABCDEF, 1'b0, 8'd1 };
    vecs[4] = '{ {8'h01,8'h00,8'h02}, {7'h01,7'h00,7'h02}, {24'h000001,24'h000000,24'h000002},
                 3'b010, {6'd5,6'd0,6'd0}, 8'h00, 7'h00, 24'h000000, 1'b1, 8'd5 };

    // Reset with go high and busy inputs: IDLE outputs must all be zero.
    clear_inputs();
    go = 1'b1; reset = 1'b1;
    score_t = {6'd8,6'd7,6'd6}; writeEn_t = 3'b111; x_t = 24'hFFFFFF;
    tick(); tick();
    go = 1'b0; reset = 1'b0;
    tick();
    check("rst_active", 32'(active), 32'(0));
    check("rst_start", 32'(start), 32'(0));
    check("rst_vga_x", 32'(vga_x), 32'(0));
    check("rst_vga_plot", 32'(vga_plot), 32'(0));
    check("rst_total", 32'(total_score), 32'(0));
    check("rst_round", 32'(round), 32'(0));
    check("rst_game_over", 32'(game_over), 32'(0));
    repeat (3) tick();
    check("idle_hold_active", 32'(active), 32'(0));
    check("idle_total", 32'(total_score), 32'(0));
    clear_inputs();

    // Scenario A: exact hold timing, round robin, pixel table, round limit.
    exp_q = {3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    pulse_go();
    tick();
    check("go_to_active", 32'(active), 32'(exp_q.pop_front()));
    begin
      bit early;
      early = 1'b0;
      done_t = 3'b001;
      for (int k = 1; k <= HOLD; k++) begin
        tick();
        if (k == 1) done_t = '0;
        if (k < HOLD && start != 3'b000) early = 1'b1;
      end
      check("start_not_early", 32'(early), 32'(0));
      check("start_pulse", 32'(start), 32'(3'b001));
      check("active_with_start", 32'(active), 32'(3'b001));
      tick();
      check("start_drop", 32'(start), 32'(0));
      check("active_drop", 32'(active), 32'(0));
    end
    writeEn_t = 3'b001;
    repeat (3) tick();
    writeEn_t = '0;
    begin
      int n;
      n = 0;
      while (round == 5'd0 && n < TO + 8) begin tick(); n++; end
      check("round_first", 32'(round), 32'(1));
    end

    check_turn();
    for (int i = 0; i < 5; i++) begin
      x_t = vecs[i].x; y_t = vecs[i].y; colour_t = vecs[i].c;
      writeEn_t = vecs[i].we; score_t = vecs[i].s;
      tick();
      check($sformatf("vec%0d_x", i), 32'(vga_x), 32'(vecs[i].ex));
      check($sformatf("vec%0d_y", i), 32'(vga_y), 32'(vecs[i].ey));
      check($sformatf("vec%0d_colour", i), 32'(vga_colour), 32'(vecs[i].ec));
      check($sformatf("vec%0d_plot", i), 32'(vga_plot), 32'(vecs[i].ep));
      check($sformatf("vec%0d_total", i), 32'(total_score), 32'(vecs[i].et));
    end
    clear_inputs();
    finish_turn(1);
    play_round(2);
    check("round_after_three", 32'(round), 32'(3));
    play_round(0);
    play_round(1);
    check("over_round_limit", 32'(game_over), 32'(1));
    check("over_round", 32'(round), 32'(RNDS));
    check("over_active", 32'(active), 32'(0));
    pulse_go();
    repeat (5) tick();
    check("over_sticky", 32'(game_over), 32'(1));
    check("over_go_ignored", 32'(active), 32'(0));
    check("over_no_start", 32'(start), 32'(0));
    writeEn_t = 3'b010; x_t = 24'h003C00;
    tick();
    check("over_mux_plot", 32'(vga_plot), 32'(1));
    check("over_mux_x", 32'(vga_x), 32'(8'h3C));
    clear_inputs();

    // Scenario B: score limit ends the game at the next GAP.
    do_reset();
    exp_q = {3'b001, 3'b010};
    pulse_go();
    play_round(0);
    check("win_not_yet", 32'(game_over), 32'(0));
    score_t = {6'd8,6'd7,6'd6};
    tick();
    check("win_total", 32'(total_score), 32'(21));
    play_round(1);
    check("win_over", 32'(game_over), 32'(1));
    check("win_round", 32'(round), 32'(2));
    repeat (4) tick();
    check("win_sticky", 32'(game_over), 32'(1));
    clear_inputs();

    // Scenario C: target 2 times out, then reset lands in HOLD.
    do_reset();
    exp_q = {3'b001, 3'b010, 3'b100, 3'b001, 3'b001};
    pulse_go();
    play_round(0);
    play_round(1);
    check_turn();
    begin
      int cnt;
      bit st_seen;
      cnt = 0; st_seen = 1'b0;
      while (active == 3'b100 && cnt < TO + 10) begin
        if (start != 3'b000) st_seen = 1'b1;
        tick(); cnt++;
      end
      while (active == 3'b000 && cnt < TO + 20) begin
        if (start != 3'b000) st_seen = 1'b1;
        tick(); cnt++;
      end
      check("timeout_len_total", 32'(cnt), 32'(TO + 2));
      check("timeout_no_start", 32'(st_seen), 32'(0));
    end
    check_turn();
    check("timeout_round", 32'(round), 32'(3));
    done_t = 3'b001; tick(); done_t = '0;
    repeat (4) tick();
    check("hold_before_reset", 32'(active), 32'(3'b001));
    writeEn_t = 3'b001;
    reset = 1'b1;
    tick();
    check("midrst_active", 32'(active), 32'(0));
    check("midrst_start", 32'(start), 32'(0));
    check("midrst_plot", 32'(vga_plot), 32'(0));
    check("midrst_round", 32'(round), 32'(0));
    reset = 1'b0; writeEn_t = '0;
    repeat (3) tick();
    check("midrst_idle", 32'(active), 32'(0));
    pulse_go();
    tick();
    check("midrst_restart_sel0", 32'(active), 32'(exp_q.pop_front()));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
